cacheline_burst_adapter: RTL
============================

# cacheline_burst_adapter

Converts single-cycle 256-bit cache line transfers from the cache datapath's physical-memory side into four 64-bit bursts on the main-memory bus, and back. It sits directly downstream of the cache's `pmem_*` port and upstream of physical memory. It presents a one-request/one-response handshake to the cache and a held-request/per-beat-response handshake to memory.

## Interface
- No parameters; line width 256, beat width 64, beats per line 4, address width 32 are fixed.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `line_i`  in  256  write-back line from cache (`pmem_wdata`).
- `line_o`  out  256  assembled fill line to cache (`pmem_rdata`).
- `address_i`  in  32  line address from cache (`pmem_address`).
- `read_i`  in  1  cache requests a line fill; held until `resp_o`.
- `write_i`  in  1  cache requests a line write-back; held until `resp_o`.
- `resp_o`  out  1  one-cycle pulse: transaction complete.
- `burst_i`  in  64  read beat from memory.
- `burst_o`  out  64  write beat to memory.
- `address_o`  out  32  burst address to memory.
- `read_o`  out  1  memory read request, held for whole burst.
- `write_o`  out  1  memory write request, held for whole burst.
- `resp_i`  in  1  memory beat strobe; one beat transferred per cycle it is high.

## Operation
- States: IDLE, READ, WRITE, DONE. 2-bit beat counter `beat`.
- IDLE: if `write_i` -> latch `line_i` into write buffer, latch address, `beat`=0, go WRITE. Else if `read_i` -> latch address, `beat`=0, go READ. `write_i` wins if both high. `resp_i` ignored.
- Latched address: `address_o` = {address_i[31:5], 5'b0}; constant for the whole transaction.
- READ: `read_o`=1. On each cycle with `resp_i`=1, store `burst_i` into `line_o[64*beat+63 : 64*beat]`, `beat`++. On the beat with `beat`==3, go DONE.
- WRITE: `write_o`=1, `burst_o` = write buffer `[64*beat+63 : 64*beat]`. Memory samples `burst_o` on each `resp_i`=1 cycle; `beat`++ on each. On the beat with `beat`==3, go DONE.
- DONE: `resp_o`=1, `read_o`=`write_o`=0, go IDLE next cycle.
- Beat order is always 0,1,2,3 (low bits first); `beat` wraps 3->0 at DONE.
- `line_o` holds its value from the last completed read until the next read overwrites it. Write transactions do not modify `line_o`.
- `read_i`/`write_i` changes outside IDLE are ignored. The cache must hold inputs stable until `resp_o`, but only the IDLE-cycle sample is used.
- `burst_o` = 0 outside WRITE.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, `beat`=0, `resp_o`=0, `read_o`=0, `write_o`=0, `address_o`=0, `burst_o`=0, `line_o`=0, write buffer=0. This applies mid-burst as well: the partial line is discarded and the request drops the next cycle.
- Request accepted at edge E (IDLE, request high). `read_o`/`write_o` and `address_o` are valid in the cycle after E.
- `resp_i` may be high in the very first cycle of READ/WRITE. Beats need not be consecutive; gaps with `resp_i`=0 stall `beat`.
- After the 4th beat edge, the next cycle has `resp_o`=1 with `line_o` complete, and `read_o`/`write_o`=0.
- Minimum latency: request sampled cycle 0, beats cycles 1–4, `resp_o` cycle 5.
- After DONE, the block is in IDLE. A request still high there starts a new transaction, so the cache must drop its request on seeing `resp_o`.
- `resp_o` is never high for two consecutive cycles.

## Test plan
- Read, back-to-back beats: `read_i`, `address_i`=0x0000_1234. Memory returns beats 0x1111…1, 0x2222…2, 0x3333…3, 0x4444…4 on cycles 1–4. Required: `address_o`=0x0000_1220; `resp_o` only on cycle 5; `line_o`={0x4444…4, 0x3333…3, 0x2222…2, 0x1111…1}.
- Write with gaps: `write_i`, `line_i`={D3,D2,D1,D0}. `resp_i` pattern 1,0,0,1,1,0,1. Required: `burst_o` shows D0, D1, D1, D1, D2, D3, D3 in those cycles; `write_o` high through the last beat; `resp_o` one cycle later.
- Simultaneous `read_i`=`write_i`=1 in IDLE: write transaction executes; `read_o` stays 0 throughout.
- Reset after 2 read beats: `read_o`=0 the next cycle, `line_o`=0, no `resp_o`. A fresh read afterwards completes normally with a correct line.
- Back-to-back read then write with the cache dropping its request on `resp_o`: exactly two `resp_o` pulses. `line_o` still holds the read data after the write completes.
- Spurious `resp_i`=1 in IDLE: no state change, `beat` stays 0, `line_o` unchanged.

Source files
------------

// File: rtl/cacheline_burst_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adapter
//
// Turns one 256-bit cache line transfer into four 64-bit memory beats, and
// back. The cache side uses a request/response handshake: the request is held
// until resp_o pulses. The memory side uses a request that stays high for the
// whole burst, plus one resp_i strobe per beat transferred.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   line_i     write-back line from cache
//   line_o     assembled fill line to cache (holds last completed read)
//   address_i  line address from cache
//   read_i     cache line-fill request
//   write_i    cache write-back request (takes priority over read_i)
//   resp_o     one-cycle completion pulse to cache
//   burst_i    read beat from memory
//   burst_o    write beat to memory (zero outside a write burst)
//   address_o  line-aligned burst address to memory
//   read_o     memory read request, held for the whole burst
//   write_o    memory write request, held for the whole burst
//   resp_i     memory beat strobe
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a cache request; resp_i is ignored
// READ  | read_o high, one burst_i beat captured per resp_i
// WRITE | write_o high, burst_o presents the current beat
// DONE  | resp_o pulse; back to IDLE next cycle
// -----------------------------------------------------------------------------
module cacheline_burst_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   beat_q,  beat_d;
  logic [31:0]  addr_q,  addr_d;
  logic [255:0] wbuf_q,  wbuf_d;
  logic [255:0] line_q,  line_d;

  // Bit offset of the current beat within the 256-bit line.
  logic [7:0]   beat_ofs;
  assign beat_ofs = {beat_q, 6'd0};

  // The line offset bits are forced to zero on the memory side.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[4:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      addr_q  <= 32'd0;
      wbuf_q  <= 256'd0;
      line_q  <= 256'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;

    case (state_q)
      IDLE: begin
        beat_d = 2'd0;
        if (write_i) begin
          wbuf_d  = line_i;
          addr_d  = {address_i[31:5], 5'd0};
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = {address_i[31:5], 5'd0};
          state_d = READ;
        end
      end

      READ: begin
        if (resp_i) begin
          // Beats land directly in the output line, low beat first.
          line_d[beat_ofs +: 64] = burst_i;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end

      WRITE: begin
        if (resp_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = 64'd0;
    case (state_q)
      READ:  read_o = 1'b1;
      WRITE: begin
        write_o = 1'b1;
        burst_o = wbuf_q[beat_ofs +: 64];
      end
      DONE:  resp_o = 1'b1;
      default: ;
    endcase
  end

  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule
